// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared encodings for the fetch sequencing controller
package fetch_ctrl_pkg;

    localparam int DataSize = 32;
    localparam logic [DataSize-1:0] DataBusReset = '0;

    typedef enum logic [1:0] {
        FC_HOLD = 2'd0,
        FC_RUN  = 2'd1,
        FC_MISS = 2'd2
    } fc_state_t;

    localparam logic [1:0] FC_PRI_NONE = 2'd0;
    localparam logic [1:0] FC_PRI_ID   = 2'd1;
    localparam logic [1:0] FC_PRI_EX   = 2'd2;
    localparam logic [1:0] FC_PRI_TRAP = 2'd3;

    // Trap and EX redirects kill the instruction already sitting in ID_EX.
    function automatic logic pri_flushes_id(input logic [1:0] pri);
        return pri >= FC_PRI_EX;
    endfunction

endpackage

// File: rtl/fetch_ctrl_arb.sv
// rtl/fetch_ctrl_arb.sv - combinational priority select across trap/EX/ID/pending redirects
module redirect_arb
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = DataSize
) (
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_target,
    input  logic            ex_req,
    input  logic [XLEN-1:0] ex_target,
    input  logic            id_req,
    input  logic [XLEN-1:0] id_target,
    input  logic            pend_valid,
    input  logic [1:0]      pend_pri,
    input  logic [XLEN-1:0] pend_target,
    output logic [1:0]      live_pri,
    output logic            sel_valid,
    output logic [1:0]      sel_pri,
    output logic [XLEN-1:0] sel_target
);

    logic [XLEN-1:0] live_target;

    always_comb begin
        live_pri    = FC_PRI_NONE;
        live_target = '0;
        if (trap_req) begin
            live_pri    = FC_PRI_TRAP;
            live_target = trap_target;
        end else if (ex_req) begin
            live_pri    = FC_PRI_EX;
            live_target = ex_target;
        end else if (id_req) begin
            live_pri    = FC_PRI_ID;
            live_target = id_target;
        end
    end

    // A live redirect wins ties against the pending one.
    always_comb begin
        sel_valid  = 1'b0;
        sel_pri    = FC_PRI_NONE;
        sel_target = '0;
        if (live_pri != FC_PRI_NONE && (!pend_valid || live_pri >= pend_pri)) begin
            sel_valid  = 1'b1;
            sel_pri    = live_pri;
            sel_target = live_target;
        end else if (pend_valid) begin
            sel_valid  = 1'b1;
            sel_pri    = pend_pri;
            sel_target = pend_target;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - decides each cycle whether the PC holds, steps or redirects
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN       = DataSize,
    parameter int RESET_HOLD = 2
) (
    input  logic            clk,
    input  logic            resetIn,
    input  logic            hazardStall,
    input  logic            icacheMiss,
    input  logic            trapReq,
    input  logic [XLEN-1:0] trapVector,
    input  logic            exRedirect,
    input  logic [XLEN-1:0] exTarget,
    input  logic            idJump,
    input  logic [XLEN-1:0] idTarget,
    output logic            pcEnable,
    output logic            pcSelect,
    output logic [XLEN-1:0] pcJumpAddr,
    output logic            flushIF,
    output logic            flushID,
    output logic [1:0]      fsmState
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    fc_state_t       state;
    logic [3:0]      hold_cnt;
    logic            pend_valid;
    logic [1:0]      pend_pri;
    logic [XLEN-1:0] pend_target;

    logic [1:0]      live_pri;
    logic            sel_valid;
    logic [1:0]      sel_pri;
    logic [XLEN-1:0] sel_target;

    // A stalled JAL re-presents once the stall lifts, so it is not a redirect now.
    redirect_arb #(.XLEN(XLEN)) u_arb (
        .trap_req    (trapReq),
        .trap_target (trapVector),
        .ex_req      (exRedirect),
        .ex_target   (exTarget),
        .id_req      (idJump & ~hazardStall),
        .id_target   (idTarget),
        .pend_valid  (pend_valid),
        .pend_pri    (pend_pri),
        .pend_target (pend_target),
        .live_pri    (live_pri),
        .sel_valid   (sel_valid),
        .sel_pri     (sel_pri),
        .sel_target  (sel_target)
    );

    assign fsmState = state;

    always_comb begin
        pcEnable   = 1'b0;
        pcSelect   = 1'b0;
        pcJumpAddr = XLEN'(DataBusReset);
        flushIF    = 1'b0;
        flushID    = 1'b0;
        if (resetIn || state == FC_HOLD) begin
            flushIF = 1'b1;
            flushID = 1'b1;
        end else if (state == FC_RUN) begin
            if (sel_valid) begin
                pcEnable   = 1'b1;
                pcSelect   = 1'b1;
                pcJumpAddr = sel_target;
                flushIF    = 1'b1;
                flushID    = pri_flushes_id(sel_pri);
            end else if (!hazardStall && icacheMiss) begin
                flushIF = 1'b1;
            end else if (!hazardStall) begin
                pcEnable = 1'b1;
            end
        end else if (state == FC_MISS) begin
            if (icacheMiss) begin
                flushIF = 1'b1;
                flushID = pri_flushes_id(live_pri);
            end else if (sel_valid) begin
                pcEnable   = 1'b1;
                pcSelect   = 1'b1;
                pcJumpAddr = sel_target;
                flushIF    = 1'b1;
                flushID    = pri_flushes_id(sel_pri);
            end else begin
                pcEnable = 1'b1;
            end
        end else begin
            flushIF = 1'b1;
            flushID = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetIn) begin
            state       <= FC_HOLD;
            hold_cnt    <= '0;
            pend_valid  <= 1'b0;
            pend_pri    <= FC_PRI_NONE;
            pend_target <= XLEN'(DataBusReset);
        end else begin
            case (state)
                FC_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= FC_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                FC_RUN: begin
                    if (!sel_valid && !hazardStall && icacheMiss) begin
                        state <= FC_MISS;
                    end
                end
                FC_MISS: begin
                    if (icacheMiss) begin
                        // sel_* already resolves live-vs-pending, so latching it keeps the winner.
                        if (sel_valid) begin
                            pend_valid  <= 1'b1;
                            pend_pri    <= sel_pri;
                            pend_target <= sel_target;
                        end
                    end else begin
                        state      <= FC_RUN;
                        pend_valid <= 1'b0;
                        pend_pri   <= FC_PRI_NONE;
                    end
                end
                default: begin
                    state    <= FC_HOLD;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the program counter. Arbitrates redirect sources (trap, EX branch resolution, ID jump) against stall sources (hazard detect, instruction-cache miss) and drives the PC's enable (`locker`), `select`, and jump-target inputs, plus flush strobes to IF_ID and ID_EX. Sits between the hazard unit, the branch/jump logic, the I-cache and `PC`. Owns all "what does the PC do next cycle" decisions.

## Interface
- `XLEN`, 32: address width; matches `DataSize`.
- `RESET_HOLD`, 2: cycles fetch stays frozen after reset deasserts (1..15).
- `clk` in 1: clock.
- `resetIn` in 1: synchronous, active-high reset.
- `hazardStall` in 1: load-use stall from hazard detect unit.
- `icacheMiss` in 1: level; I-cache cannot deliver the current PC's instruction.
- `trapReq` in 1, `trapVector` in XLEN: trap/exception redirect.
- `exRedirect` in 1, `exTarget` in XLEN: taken or mispredicted branch resolved in EX.
- `idJump` in 1, `idTarget` in XLEN: JAL decoded in ID.
- `pcEnable` out 1: to `PC.locker`; 1 = PC updates.
- `pcSelect` out 1: to `PC.select`; 1 = load `pcJumpAddr`, 0 = PC+4.
- `pcJumpAddr` out XLEN: to `PC.addrJump`.
- `flushIF` out 1: clear IF_ID at next edge.
- `flushID` out 1: clear ID_EX at next edge.
- `fsmState` out 2: debug.

## Operation
- States: HOLD(0), RUN(1), MISS(2).
- Registers: state, hold counter (4b), pending-valid, pending-priority (2b), pending-target (XLEN).
- Redirect priority: trap (3) > exRedirect (2) > idJump (1). One redirect is selected per cycle.
- `idJump` is ignored while `hazardStall` = 1, because the jump is itself stalled and re-presents.
- HOLD: `pcEnable`=0, `pcSelect`=0, `pcJumpAddr`=0, `flushIF`=`flushID`=1. Counter counts RESET_HOLD cycles, then goes to RUN.
- RUN, with a redirect selected: `pcEnable`=1, `pcSelect`=1, `pcJumpAddr`=target, `flushIF`=1. `flushID`=1 only for trap or exRedirect. Redirect overrides `hazardStall` and `icacheMiss`.
- RUN, no redirect, `hazardStall`=1: `pcEnable`=0, no flush.
- RUN, no redirect, `icacheMiss`=1: `pcEnable`=0, `flushIF`=1 (bubble), go to MISS.
- RUN, otherwise: `pcEnable`=1, `pcSelect`=0.
- MISS: `pcEnable`=0, `flushIF`=1.
  - A redirect arriving in MISS is latched into pending if pending is empty or its priority ≥ pending priority. `flushID` asserts that cycle for trap/EX.
  - When `icacheMiss` drops:
    - pending valid: issue it (`pcEnable`=1, `pcSelect`=1, target=pending, `flushIF`=1), clear pending, go to RUN.
    - pending empty: `pcEnable`=1, `pcSelect`=0, go to RUN.
    - a live redirect in the same cycle: it is compared with pending by priority, and the higher one issues; ties go to the live one.
- `resetIn` in any state: state←HOLD, counter←0, pending cleared. Outputs take their HOLD values in the reset cycle itself.

## Timing
- Outputs are combinational from state, pending and inputs. `PC` registers them at the next edge, so redirect-to-new-PC latency is 1 cycle.
- Flushes are level signals, one per decision cycle; pipeline registers clear at the following edge.
- Exit from HOLD is exactly RESET_HOLD cycles after the first cycle with `resetIn`=0. The first `pcEnable`=1 occurs in cycle RESET_HOLD+1.
- Pending target is captured at the edge ending the redirect cycle. A pending redirect issues in the first cycle with `icacheMiss`=0.
- No combinational path from `pcJumpAddr` back into the arbitration.

## Structure
- Shared package (`define.v` additions):
  - state encodings `FC_HOLD`/`FC_RUN`/`FC_MISS`
  - priority codes `FC_PRI_NONE/ID/EX/TRAP`
  - reuse `DataSize` and `DataBusReset`
- Sub-module `redirect_arb`: combinational priority select of {valid, priority, target} across trap/EX/ID/pending. This module is the sequencer around it.

## Test plan
- Reset for 3 cycles, then release with RESET_HOLD=2 -> flushes=1 and `pcEnable`=0 for 2 cycles; RUN entered and `pcEnable`=1 on the 3rd cycle; `fsmState`=1.
- RUN, `exRedirect`=1, `exTarget`=0x0000_0100, `hazardStall`=1 in the same cycle -> `pcEnable`=1, `pcSelect`=1, `pcJumpAddr`=0x100, `flushIF`=`flushID`=1.
- RUN, `idJump`=1 (0x40) with `hazardStall`=1 -> `pcEnable`=0 and no flush; next cycle `hazardStall`=0 -> jump to 0x40 with `flushIF`=1 and `flushID`=0.
- `icacheMiss` for 4 cycles; `idJump`(0x40) in the 2nd cycle, `exRedirect`(0x80) in the 3rd -> pending=0x80. On the miss clear: `pcSelect`=1, `pcJumpAddr`=0x80, state→RUN.
- MISS with pending EX 0x80; `trapReq`(0x200) coincides with the miss clear -> trap issues, `pcJumpAddr`=0x200, pending cleared.
- `resetIn` asserted while in MISS with pending valid -> next cycle `fsmState`=0, pending cleared, `pcEnable`=0; after hold, no stale redirect issues.
